display_clock_reconfig: RTL and testbench
=========================================

DISPLAY_CLOCK_RECONFIG -- requirements
Module: display_clock_reconfig

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4: number of selectable pixel-clock modes.
REQ-002 SHALL have parameter NUM_REGS, default 8: DRP register writes per mode.
REQ-003 SHALL have parameter MODE_TABLE, default all-zero: NUM_MODES*NUM_REGS entries of {addr[6:0], mask[15:0], value[15:0]}, entry 0 in the LSBs, indexed mode*NUM_REGS+reg.
REQ-004 SHALL have parameter DRP_TIMEOUT, default 64: maximum cycles from o_den to i_drdy.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum cycles from MMCM reset release to lock.
REQ-006 SHALL have port i_clk, input, 1: DRP and control clock; the design uses only this clock.
REQ-007 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port i_start, input, 1: request a reconfiguration to i_mode.
REQ-009 SHALL have port i_mode, input, $clog2(NUM_MODES): requested mode.
REQ-010 SHALL have port o_busy, output, 1: reconfiguration in progress.
REQ-011 SHALL have port o_done, output, 1: one-cycle pulse on successful completion.
REQ-012 SHALL have port o_error, output, 1: sticky failure flag.
REQ-013 SHALL have port o_mode_active, output, $clog2(NUM_MODES): last successfully applied mode.
REQ-014 SHALL have port o_mmcm_rst, output, 1: MMCM reset, active-high.
REQ-015 SHALL have ports o_daddr (output, 7), o_den (output, 1), o_dwe (output, 1), o_di (output, 16), i_do (input, 16), i_drdy (input, 1): the MMCM DRP.
REQ-016 SHALL have port i_locked, input, 1: raw, asynchronous MMCM LOCKED.
REQ-017 SHALL have port o_locked, output, 1: qualified lock, i.e. synchronised lock AND NOT o_busy.

Function
REQ-018 SHALL synchronise i_locked through two flops before any use.
REQ-019 SHALL accept i_start only in IDLE; it SHALL ignore i_start at all other times.
REQ-020 On accept, SHALL latch i_mode, clear o_error and set o_busy the next cycle.
REQ-021 SHALL reject i_mode >= NUM_MODES by setting o_error and returning to IDLE with no DRP or reset activity.
REQ-022 FSM SHALL use the states IDLE, RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE, ERR.
REQ-023 RST SHALL assert o_mmcm_rst and hold it through WAIT_WR of the last register.
REQ-024 RD SHALL drive o_den=1, o_dwe=0 and o_daddr=entry.addr for exactly one cycle.
REQ-025 WAIT_RD SHALL wait for i_drdy and capture i_do on that cycle.
REQ-026 WR SHALL drive o_den=1, o_dwe=1 and o_di=(captured & mask) | (value & ~mask) for exactly one cycle.
REQ-027 WAIT_WR on i_drdy SHALL increment the register index and go to RD, or go to RELEASE after index NUM_REGS-1.
REQ-028 RELEASE SHALL deassert o_mmcm_rst; WAIT_LOCK SHALL wait for the synchronised lock.
REQ-029 DONE SHALL pulse o_done for one cycle, update o_mode_active, clear o_busy and return to IDLE.
REQ-030 If i_drdy is absent for DRP_TIMEOUT cycles, or lock is absent for LOCK_TIMEOUT cycles, SHALL go to ERR.
REQ-031 ERR SHALL deassert o_mmcm_rst, set o_error, clear o_busy, keep o_mode_active unchanged and return to IDLE.
REQ-032 SHALL ignore i_drdy outside WAIT_RD and WAIT_WR.
REQ-033 o_den SHALL never be asserted on two consecutive cycles.

Reset
REQ-034 On i_rst_n=0, SHALL immediately set all outputs to 0, the FSM to IDLE, the register index to 0 and the synchroniser flops to 0.
REQ-035 Reset mid-operation SHALL abort the sequence and deassert o_mmcm_rst; no partial state SHALL survive.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the entry field widths (7/16/16) and the entry-unpack function.
REQ-037 The 2-flop synchroniser SHALL be the sub-module sync_2ff; all other logic SHALL be in one module.

Verification
REQ-038 Bench SHALL drive mode 1 with NUM_REGS=2, a DRP model answering after 3 cycles, and i_do=0xFFFF; each write SHALL carry (0xFFFF & mask) | value, followed by o_done, o_mode_active=1 and o_mmcm_rst low.
REQ-039 Bench SHALL drive i_mode=NUM_MODES; o_error SHALL be 1 with no o_den pulse and o_mmcm_rst staying 0.
REQ-040 Bench SHALL withhold i_drdy on the second read; ERR SHALL be reached DRP_TIMEOUT cycles later with o_mode_active unchanged.
REQ-041 Bench SHALL hold i_locked low after release; o_error SHALL rise LOCK_TIMEOUT cycles later.
REQ-042 Bench SHALL pulse i_start during WAIT_WR and then assert i_rst_n=0 mid-write; the start SHALL be ignored and all outputs SHALL go to 0 asynchronously.

Source files
------------

// File: rtl/display_clock_reconfig_pkg.sv
// Shared types for the MMCM DRP reconfiguration block:
// FSM states, DRP table entry layout, entry unpack and merge helpers.
package display_clock_reconfig_pkg;

  localparam int ADDR_W  = 7;
  localparam int MASK_W  = 16;
  localparam int VAL_W   = 16;
  localparam int ENTRY_W = ADDR_W + MASK_W + VAL_W;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    RD,
    WAIT_RD,
    WR,
    WAIT_WR,
    RELEASE,
    WAIT_LOCK,
    DONE,
    ERR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [VAL_W-1:0]  value;
  } entry_t;

  // Raw entry layout: {addr, mask, value}, value in the LSBs.
  function automatic entry_t unpack_entry(
    input logic [ENTRY_W-1:0] raw
  );
    entry_t e;
    e.addr  = raw[ENTRY_W-1 -: ADDR_W];
    e.mask  = raw[VAL_W +: MASK_W];
    e.value = raw[VAL_W-1:0];
    return e;
  endfunction

  // Mask bits keep the read-back content, the rest take value.
  function automatic logic [VAL_W-1:0] merge_word(
    input logic [VAL_W-1:0]  cur,
    input logic [MASK_W-1:0] mask,
    input logic [VAL_W-1:0]  value
  );
    return (cur & mask) | (value & ~mask);
  endfunction

endpackage

// File: rtl/display_clock_reconfig_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async low), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/display_clock_reconfig.sv
// Pixel-clock reconfiguration: holds the MMCM in reset, read-modify-writes
// a per-mode list of DRP registers, releases reset and waits for lock.
// Ports: i_start/i_mode request, o_busy/o_done/o_error/o_mode_active status,
// o_mmcm_rst, DRP bus (o_daddr/o_den/o_dwe/o_di/i_do/i_drdy),
// i_locked raw lock in, o_locked qualified lock out.
module display_clock_reconfig
  import display_clock_reconfig_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int NUM_REGS     = 8,
  parameter logic [NUM_MODES*NUM_REGS*ENTRY_W-1:0] MODE_TABLE = '0,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [$clog2(NUM_MODES)-1:0] i_mode,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [$clog2(NUM_MODES)-1:0] o_mode_active,
  output logic                         o_mmcm_rst,
  output logic [ADDR_W-1:0]            o_daddr,
  output logic                         o_den,
  output logic                         o_dwe,
  output logic [VAL_W-1:0]             o_di,
  input  logic [VAL_W-1:0]             i_do,
  input  logic                         i_drdy,
  input  logic                         i_locked,
  output logic                         o_locked
);

  localparam int MW   = $clog2(NUM_MODES);
  localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NE   = NUM_MODES * NUM_REGS;
  localparam int SW   = (NE > 1) ? $clog2(NE) : 1;
  localparam int TMAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ?
                        DRP_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [MW:0]    MODE_LIM = (MW+1)'(NUM_MODES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [TW-1:0]  DRP_LIM  = TW'(DRP_TIMEOUT);
  localparam logic [TW-1:0]  LOCK_LIM = TW'(LOCK_TIMEOUT);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [MW-1:0]     mode_q, mode_d;
  logic [MW-1:0]     active_q, active_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mmcm_rst_q, mmcm_rst_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic [VAL_W-1:0]  di_q, di_d;

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_locked),
    .q     (lock_s)
  );

  entry_t tbl [NE];

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      tbl[i] = unpack_entry(MODE_TABLE[i*ENTRY_W +: ENTRY_W]);
    end
  end

  // Addresses are registered on the way into RD, so the
  // lookup runs one register ahead while leaving WAIT_WR.
  logic [IW-1:0]     rd_idx;
  logic [SW-1:0]     rd_sel;
  logic [SW-1:0]     cur_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [MASK_W-1:0] cur_mask;
  logic [VAL_W-1:0]  cur_value;
  logic              is_last;
  logic              bad_mode;

  assign rd_idx    = (state_q == WAIT_WR) ? idx_q + IW'(1) : idx_q;
  assign rd_sel    = SW'(mode_q) * SW'(NUM_REGS) + SW'(rd_idx);
  assign cur_sel   = SW'(mode_q) * SW'(NUM_REGS) + SW'(idx_q);
  assign rd_addr   = tbl[rd_sel].addr;
  assign cur_mask  = tbl[cur_sel].mask;
  assign cur_value = tbl[cur_sel].value;
  assign is_last   = (idx_q == LAST_IDX);
  assign bad_mode  = ({1'b0, i_mode} >= MODE_LIM);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    mode_d     = mode_q;
    active_d   = active_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    mmcm_rst_d = mmcm_rst_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    di_d       = di_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (bad_mode) begin
            error_d = 1'b1;
          end else begin
            mode_d     = i_mode;
            error_d    = 1'b0;
            busy_d     = 1'b1;
            mmcm_rst_d = 1'b1;
            idx_d      = '0;
            tmr_d      = '0;
            state_d    = RST;
          end
        end
      end
      RST: begin
        den_d   = 1'b1;
        daddr_d = rd_addr;
        state_d = RD;
      end
      RD: begin
        tmr_d   = TW'(1);
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (i_drdy) begin
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          di_d    = merge_word(i_do, cur_mask, cur_value);
          state_d = WR;
        end else if (tmr_q == DRP_LIM) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WR: begin
        tmr_d   = TW'(1);
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (i_drdy) begin
          if (is_last) begin
            idx_d      = '0;
            mmcm_rst_d = 1'b0;
            state_d    = RELEASE;
          end else begin
            idx_d   = rd_idx;
            den_d   = 1'b1;
            daddr_d = rd_addr;
            state_d = RD;
          end
        end else if (tmr_q == DRP_LIM) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      RELEASE: begin
        tmr_d   = TW'(1);
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          active_d = mode_q;
          state_d  = DONE;
        end else if (tmr_q == LOCK_LIM) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering ERR drops everything but the applied mode.
    if (state_d == ERR && state_q != ERR) begin
      error_d    = 1'b1;
      busy_d     = 1'b0;
      mmcm_rst_d = 1'b0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      mode_q     <= '0;
      active_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mmcm_rst_q <= 1'b0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      mode_q     <= mode_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mmcm_rst_q <= mmcm_rst_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      di_q       <= di_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_mode_active = active_q;
  assign o_mmcm_rst    = mmcm_rst_q;
  assign o_daddr       = daddr_q;
  assign o_den         = den_q;
  assign o_dwe         = dwe_q;
  assign o_di          = di_q;
  assign o_locked      = lock_s & ~busy_q;

endmodule

// File: tb/tb_display_clock_reconfig.sv
// Bench for display_clock_reconfig: DRP/MMCM model, vector table,
// random requests and hand-written timeout/reset sequences.
module tb_display_clock_reconfig;

  localparam int NM = 3;
  localparam int NR = 2;
  localparam int DT = 16;
  localparam int LT = 40;
  localparam int EW = 39;

  localparam logic [EW-1:0] E00 = {7'h08, 16'hF000, 16'h0123};
  localparam logic [EW-1:0] E01 = {7'h09, 16'h00FF, 16'h1200};
  localparam logic [EW-1:0] E10 = {7'h14, 16'hFF00, 16'h0042};
  localparam logic [EW-1:0] E11 = {7'h15, 16'h0F0F, 16'hA050};
  localparam logic [EW-1:0] E20 = {7'h28, 16'h8001, 16'h1234};
  localparam logic [EW-1:0] E21 = {7'h4E, 16'h0000, 16'hBEEF};
  localparam logic [NM*NR*EW-1:0] TBL = {E21, E20, E11, E10, E01, E00};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        o_busy, o_done, o_error, o_mmcm_rst;
  logic [1:0]  o_mode_active;
  logic [6:0]  o_daddr;
  logic        o_den, o_dwe, o_locked;
  logic [15:0] o_di;
  logic [15:0] i_do = 16'h0;
  logic        i_drdy = 1'b0;
  logic        i_locked = 1'b0;

  always #5 clk = ~clk;

  display_clock_reconfig #(
    .NUM_MODES    (NM),
    .NUM_REGS     (NR),
    .MODE_TABLE   (TBL),
    .DRP_TIMEOUT  (DT),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_mode        (mode),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_mode_active (o_mode_active),
    .o_mmcm_rst    (o_mmcm_rst),
    .o_daddr       (o_daddr),
    .o_den         (o_den),
    .o_dwe         (o_dwe),
    .o_di          (o_di),
    .i_do          (i_do),
    .i_drdy        (i_drdy),
    .i_locked      (i_locked),
    .o_locked      (o_locked)
  );

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int den_cnt = 0;
  bit mmcm_seen = 0;
  int exp_mode = 0;
  int drp_lat = 3;
  bit fix_ff = 0;
  int hold_rd = 0;
  bit lock_en = 1;
  int pend = 0;
  int lk_cnt = 0;
  int t_den_hold = 0;
  int t_rel = 0;
  int t_end = 0;
  bit prev_den = 0;
  bit prev_rst = 0;
  logic [15:0] rsp = 16'h0;
  logic [15:0] last_rd = 16'h0;
  logic [EW-1:0] m_e;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int m, input int r);
    logic [NM*NR*EW-1:0] t;
    t = TBL >> ((m * NR + r) * EW);
    return t[EW-1:0];
  endfunction

  task automatic wait_cyc();
    @(negedge clk);
    #1;
  endtask

  // DRP slave, MMCM lock and bus checker; all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    i_drdy = 1'b0;
    i_do   = 16'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_drdy = 1'b1;
        i_do   = rsp;
      end
    end
    if (!rst_n) begin
      prev_den = 0;
      pend     = 0;
    end else begin
      if (o_den) begin
        m_e = ent(exp_mode, den_cnt / 2);
        chk("den_gap", 64'(prev_den), 64'(0));
        if (den_cnt % 2 == 0) begin
          chk("rd_addr", 64'({o_dwe, o_daddr}),
              64'({1'b0, m_e[38:32]}));
          last_rd = fix_ff ? 16'hFFFF : 16'($urandom);
          rsp = last_rd;
          if (hold_rd == den_cnt / 2 + 1) begin
            pend = -1;
            t_den_hold = cyc;
          end else begin
            pend = drp_lat;
          end
        end else begin
          chk("wr_data", 64'({o_dwe, o_daddr, o_di}),
              64'({1'b1, m_e[38:32],
                   (last_rd & m_e[31:16]) |
                   (m_e[15:0] & ~m_e[31:16])}));
          pend = drp_lat;
        end
        den_cnt++;
      end
      prev_den = o_den;
      if (o_mmcm_rst) mmcm_seen = 1;
      if (prev_rst && !o_mmcm_rst) t_rel = cyc;
    end
    prev_rst = o_mmcm_rst;
    if (o_mmcm_rst || !rst_n) lk_cnt = 0;
    else if (lk_cnt < 1000) lk_cnt++;
    i_locked = lock_en && (lk_cnt >= 4);
  end

  task automatic run_txn(input int m, input int lat, input bit ff,
                         input bit exp_err, input int exp_act);
    int i;
    drp_lat   = lat;
    fix_ff    = ff;
    exp_mode  = m;
    den_cnt   = 0;
    mmcm_seen = 0;
    mode  = 2'(m);
    start = 1'b1;
    wait_cyc();
    start = 1'b0;
    i = 0;
    while (!(o_done || o_error) && i < 300) begin
      wait_cyc();
      i++;
    end
    t_end = cyc;
    chk("result_in_time", 64'(i < 300), 64'(1));
    chk("error", 64'(o_error), 64'(exp_err));
    chk("mode_active", 64'(o_mode_active), 64'(exp_act));
    chk("busy_clear", 64'(o_busy), 64'(0));
    chk("mmcm_rst_low", 64'(o_mmcm_rst), 64'(0));
    if (!exp_err) begin
      chk("done", 64'(o_done), 64'(1));
      chk("den_count", 64'(den_cnt), 64'(2 * NR));
      wait_cyc();
      chk("done_pulse_width", 64'(o_done), 64'(0));
      chk("locked_qualified", 64'(o_locked), 64'(1));
    end else if (m >= NM) begin
      repeat (3) wait_cyc();
      chk("bad_mode_no_den", 64'(den_cnt), 64'(0));
      chk("bad_mode_no_rst", 64'(mmcm_seen), 64'(0));
    end
    repeat (2) wait_cyc();
  endtask

  typedef struct {
    int m;
    int lat;
    bit ff;
    bit err;
    int act;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int act;
    int i;
    vecs[0] = '{m: 1, lat: 3,  ff: 1, err: 0, act: 1};
    vecs[1] = '{m: 0, lat: 1,  ff: 0, err: 0, act: 0};
    vecs[2] = '{m: 2, lat: DT, ff: 0, err: 0, act: 2};
    vecs[3] = '{m: 3, lat: 3,  ff: 0, err: 1, act: 2};
    vecs[4] = '{m: 1, lat: DT + 1, ff: 0, err: 1, act: 2};
    vecs[5] = '{m: 1, lat: 2,  ff: 0, err: 0, act: 1};

    repeat (2) wait_cyc();
    chk("reset_state", 64'({o_busy, o_done, o_error, o_mode_active,
        o_mmcm_rst, o_daddr, o_den, o_dwe, o_di, o_locked}), 64'(0));
    rst_n = 1'b1;
    repeat (10) wait_cyc();
    chk("idle_locked", 64'(o_locked), 64'(1));

    foreach (vecs[k]) begin
      run_txn(vecs[k].m, vecs[k].lat, vecs[k].ff,
              vecs[k].err, vecs[k].act);
    end

    act = 1;
    for (int k = 0; k < 20; k++) begin
      int m;
      int lat;
      bit err;
      m   = int'($urandom_range(0, 3));
      lat = int'($urandom_range(1, DT + 2));
      err = (m >= NM) || (lat > DT);
      if (!err) act = m;
      run_txn(m, lat, 1'b0, err, act);
    end

    hold_rd = 2;
    run_txn(0, 3, 1'b0, 1'b1, act);
    chk("drp_timeout_cycles", 64'(t_end - t_den_hold), 64'(DT + 1));
    hold_rd = 0;

    lock_en = 0;
    run_txn(2, 2, 1'b0, 1'b1, act);
    chk("lock_timeout_cycles", 64'(t_end - t_rel), 64'(LT + 1));
    lock_en = 1;
    repeat (10) wait_cyc();

    drp_lat  = 3;
    fix_ff   = 0;
    exp_mode = 1;
    den_cnt  = 0;
    mode  = 2'd1;
    start = 1'b1;
    wait_cyc();
    start = 1'b0;
    i = 0;
    while (den_cnt < 2 && i < 100) begin
      wait_cyc();
      i++;
    end
    wait_cyc();
    mode  = 2'd2;
    start = 1'b1;
    wait_cyc();
    start = 1'b0;
    chk("busy_during_op", 64'(o_busy), 64'(1));
    chk("locked_masked", 64'(o_locked), 64'(0));
    while (den_cnt < 4 && i < 200) begin
      wait_cyc();
      i++;
    end
    chk("second_write_seen", 64'(den_cnt), 64'(4));
    chk("pre_reset_den", 64'({o_den, o_mmcm_rst}), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({o_busy, o_done, o_error,
        o_mode_active, o_mmcm_rst, o_daddr, o_den, o_dwe, o_di,
        o_locked}), 64'(0));
    repeat (2) wait_cyc();
    rst_n = 1'b1;
    repeat (10) wait_cyc();
    run_txn(0, 2, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
